// File: rtl/fdiv_mul_if.sv
// Operand/result bundle between the finv front end, fdiv_mul and the FPU writeback mux.
// The master side issues x with its reciprocal; the slave side returns the quotient.
interface fdiv_mul_if;
    logic        in_valid;
    logic [31:0] x;
    logic [31:0] inv;
    logic        out_valid;
    logic [31:0] z;

    modport master (output in_valid, x, inv, input out_valid, z);
    modport slave  (input in_valid, x, inv, output out_valid, z);
endinterface

// File: rtl/fdiv_mul.sv
// Divider back end: z = x * (1/y). x is delayed to meet the finv result, then a
// two-stage binary32 multiply (flush-to-zero, round-to-nearest-even) produces z.
module fdiv_mul #(
    parameter int unsigned FINV_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    fdiv_mul_if.slave  bus
);

    logic [31:0] x_d;
    logic        v_d;

    generate
        if (FINV_LAT == 0) begin : g_wire
            assign x_d = bus.x;
            assign v_d = bus.in_valid;
        end else begin : g_chain
            logic [31:0] x_sr [FINV_LAT];
            logic        v_sr [FINV_LAT];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int unsigned i = 0; i < FINV_LAT; i++) begin
                        x_sr[i] <= '0;
                        v_sr[i] <= 1'b0;
                    end
                end else begin
                    x_sr[0] <= bus.x;
                    v_sr[0] <= bus.in_valid;
                    for (int unsigned i = 1; i < FINV_LAT; i++) begin
                        x_sr[i] <= x_sr[i-1];
                        v_sr[i] <= v_sr[i-1];
                    end
                end
            end

            assign x_d = x_sr[FINV_LAT-1];
            assign v_d = v_sr[FINV_LAT-1];
        end
    endgenerate

    // Stage M1: sign, biased exponent sum, full significand product, operand classes.
    logic [7:0]         ex, ei;
    logic [22:0]        fx, fi;
    logic               zero_x, zero_i, inf_x, inf_i, nan_x, nan_i;
    logic signed [9:0]  e_sum;
    logic [47:0]        p_full;

    assign ex     = x_d[30:23];
    assign fx     = x_d[22:0];
    assign ei     = bus.inv[30:23];
    assign fi     = bus.inv[22:0];
    assign zero_x = (ex == '0);
    assign zero_i = (ei == '0);
    assign inf_x  = (ex == '1) && (fx == '0);
    assign inf_i  = (ei == '1) && (fi == '0);
    assign nan_x  = (ex == '1) && (fx != '0);
    assign nan_i  = (ei == '1) && (fi != '0);
    assign e_sum  = $signed({2'b00, ex}) + $signed({2'b00, ei}) - 10'sd127;
    assign p_full = 48'({1'b1, fx}) * 48'({1'b1, fi});

    logic               m1_v, m1_sign, m1_nan, m1_inf, m1_zero;
    logic signed [9:0]  m1_e;
    logic [47:0]        m1_p;

    always_ff @(posedge clk) begin
        if (rst) begin
            m1_v    <= 1'b0;
            m1_sign <= 1'b0;
            m1_nan  <= 1'b0;
            m1_inf  <= 1'b0;
            m1_zero <= 1'b0;
            m1_e    <= '0;
            m1_p    <= '0;
        end else begin
            m1_v    <= v_d;
            m1_sign <= x_d[31] ^ bus.inv[31];
            m1_nan  <= nan_x | nan_i | (inf_x & zero_i) | (zero_x & inf_i);
            m1_inf  <= inf_x | inf_i;
            m1_zero <= zero_x | zero_i;
            m1_e    <= e_sum;
            m1_p    <= p_full;
        end
    end

    // Stage M2: normalise, round, apply special-case priority.
    logic [22:0]        mant;
    logic               guard, sticky;
    logic [23:0]        rnd;
    logic signed [9:0]  e_norm, e_fin;
    logic [31:0]        res;

    always_comb begin
        if (m1_p[47]) begin
            mant   = m1_p[46:24];
            guard  = m1_p[23];
            sticky = |m1_p[22:0];
            e_norm = m1_e + 10'sd1;
        end else begin
            mant   = m1_p[45:23];
            guard  = m1_p[22];
            sticky = |m1_p[21:0];
            e_norm = m1_e;
        end
        // A carry out of the rounded fraction leaves the fraction at zero, so only e moves.
        rnd   = {1'b0, mant} + 24'(guard & (sticky | mant[0]));
        e_fin = rnd[23] ? e_norm + 10'sd1 : e_norm;

        if (m1_nan)
            res = 32'h7FC0_0000;
        else if (m1_inf)
            res = {m1_sign, 8'hFF, 23'h0};
        else if (m1_zero)
            res = {m1_sign, 31'h0};
        else if (e_fin >= 10'sd255)
            res = {m1_sign, 8'hFF, 23'h0};
        else if (e_fin <= 10'sd0)
            res = {m1_sign, 31'h0};
        else
            res = {m1_sign, e_fin[7:0], rnd[22:0]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.z         <= '0;
        end else begin
            bus.out_valid <= m1_v;
            bus.z         <= res;
        end
    end

endmodule

// File: tb/tb_fdiv_mul.sv
// Bench for fdiv_mul: three instances (FINV_LAT 0, 1, 3) share one operand stream and are
// checked every cycle against an arithmetic reference model and a per-instance schedule.
module tb_fdiv_mul;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    fdiv_mul_if bus0 ();
    fdiv_mul_if bus1 ();
    fdiv_mul_if bus3 ();

    fdiv_mul #(.FINV_LAT(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
    fdiv_mul #(.FINV_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
    fdiv_mul #(.FINV_LAT(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));

    localparam int LATS [3] = '{0, 1, 3};

    logic        ov [3];
    logic [31:0] zz [3];
    assign ov[0] = bus0.out_valid;
    assign ov[1] = bus1.out_valid;
    assign ov[2] = bus3.out_valid;
    assign zz[0] = bus0.z;
    assign zz[1] = bus1.z;
    assign zz[2] = bus3.z;

    typedef struct {
        int          cyc;
        logic [31:0] z;
    } exp_t;

    exp_t        expq [3][$];
    int          cyc;
    int          n_cmp;
    int          n_fail;
    logic [31:0] hist [4];

    // Reference: exact significand product in double precision, rounded to 24 bits by hand.
    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        logic [7:0]  ea, eb;
        logic [22:0] fa, fb;
        real         q, t, fl;
        longint      m;
        int          e;
        s  = a[31] ^ b[31];
        ea = a[30:23];
        eb = b[30:23];
        fa = a[22:0];
        fb = b[22:0];
        if ((ea == 8'hFF && fa != 0) || (eb == 8'hFF && fb != 0) ||
            (ea == 8'hFF && eb == 0) || (eb == 8'hFF && ea == 0))
            return 32'h7FC00000;
        if (ea == 8'hFF || eb == 8'hFF)
            return {s, 8'hFF, 23'h0};
        if (ea == 0 || eb == 0)
            return {s, 31'h0};
        q = (1.0 + real'(fa) / 8388608.0) * (1.0 + real'(fb) / 8388608.0);
        e = int'(ea) + int'(eb) - 127;
        if (q >= 2.0) begin
            q = q / 2.0;
            e = e + 1;
        end
        t  = q * 8388608.0;
        fl = $floor(t);
        m  = longint'(fl);
        if ((t - fl) > 0.5 || ((t - fl) == 0.5 && m[0]))
            m = m + 1;
        if (m == 64'd16777216) begin
            m = 64'd8388608;
            e = e + 1;
        end
        if (e >= 255)
            return {s, 8'hFF, 23'h0};
        if (e <= 0)
            return {s, 31'h0};
        return {s, 8'(e), 23'(m)};
    endfunction

    function automatic logic [31:0] rand_float();
        int unsigned sel;
        logic        s;
        logic [7:0]  e;
        logic [22:0] f;
        sel = $urandom_range(0, 31);
        s   = 1'($urandom());
        f   = 23'($urandom());
        case (sel)
            0:       e = 8'h00;
            1:       begin e = 8'hFF; f = '0; end
            2:       begin e = 8'hFF; f = f | 23'h1; end
            3:       e = 8'h00;
            4:       begin e = 8'($urandom_range(120, 134)); f = '1; end
            default: e = (sel < 22) ? 8'($urandom_range(100, 154)) : 8'($urandom_range(1, 254));
        endcase
        if (sel == 0) f = '0;
        return {s, e, f};
    endfunction

    task automatic tick();
        logic r;
        r = rst;
        @(posedge clk);
        #1;
        cyc++;
        if (r)
            for (int k = 0; k < 3; k++) expq[k].delete();
    endtask

    // Drives one issue slot; each instance sees the inv matching its own FINV_LAT.
    task automatic issue(input logic v, input logic [31:0] xv, input logic [31:0] iv,
                         input logic [31:0] ez);
        logic [31:0] xd;
        for (int j = 3; j > 0; j--) hist[j] = hist[j-1];
        hist[0] = v ? iv : $urandom();
        xd = v ? xv : $urandom();
        bus0.in_valid = v;  bus1.in_valid = v;  bus3.in_valid = v;
        bus0.x = xd;        bus1.x = xd;        bus3.x = xd;
        bus0.inv = hist[0];
        bus1.inv = hist[1];
        bus3.inv = hist[3];
        if (v && !rst)
            for (int k = 0; k < 3; k++) expq[k].push_back('{cyc + LATS[k] + 2, ez});
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            issue(1'b1, rand_float(), rand_float(), 32'h0);
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (ov[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_out_valid lat%0d: got %b want 0", LATS[k], ov[k]);
            end
            n_cmp++;
            if (zz[k] !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_z lat%0d: got %h want 00000000", LATS[k], zz[k]);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [31:0] vx [12];
        logic [31:0] vi [12];
        logic [31:0] vz [12];
        vx = '{32'h40C00000, 32'h3FFFFFFF, 32'h7F000000, 32'h00800000, 32'h00000000, 32'hC0000000,
               32'h7FC00001, 32'hFF800000, 32'h00400000, 32'h3F800000, 32'hBFC00000, 32'h3F800001};
        vi = '{32'h3F000000, 32'h3FFFFFFF, 32'h40800000, 32'h3E800000, 32'h7F800000, 32'h00000000,
               32'h3F800000, 32'h40000000, 32'h40000000, 32'h3F800000, 32'h40000000, 32'h3FFFFFFE};
        vz = '{32'h40400000, 32'h407FFFFE, 32'h7F800000, 32'h00000000, 32'h7FC00000, 32'h80000000,
               32'h7FC00000, 32'hFF800000, 32'h00000000, 32'h3F800000, 32'hC0400000, 32'h40000000};
        for (int i = 0; i < 12 + 8; i++) begin
            if (i < 12) issue(1'b1, vx[i], vi[i], vz[i]);
            else        issue(1'b0, 32'h0, 32'h0, 32'h0);
            tick();
            for (int k = 0; k < 3; k++) begin
                logic ev;
                ev = (expq[k].size() > 0) && (expq[k][0].cyc == cyc);
                n_cmp++;
                if (ov[k] !== ev) begin
                    n_fail++;
                    $display("FAIL directed_valid lat%0d cyc %0d: got %b want %b", LATS[k], cyc, ov[k], ev);
                end
                if (ev) begin
                    n_cmp++;
                    if (zz[k] !== expq[k][0].z) begin
                        n_fail++;
                        $display("FAIL directed_z lat%0d cyc %0d: got %h want %h", LATS[k], cyc, zz[k], expq[k][0].z);
                    end
                    void'(expq[k].pop_front());
                end
            end
        end
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (expq[k].size() != 0) begin
                n_fail++;
                $display("FAIL directed_drain lat%0d: got %0d outstanding want 0", LATS[k], expq[k].size());
            end
        end
    endtask

    task automatic test_stream(input int n, input int unsigned gap_pct);
        for (int i = 0; i < n + 8; i++) begin
            logic [31:0] a, b;
            a = rand_float();
            b = rand_float();
            if (i < n && $urandom_range(1, 100) > gap_pct) issue(1'b1, a, b, ref_mul(a, b));
            else                                             issue(1'b0, a, b, 32'h0);
            tick();
            for (int k = 0; k < 3; k++) begin
                logic ev;
                ev = (expq[k].size() > 0) && (expq[k][0].cyc == cyc);
                n_cmp++;
                if (ov[k] !== ev) begin
                    n_fail++;
                    $display("FAIL stream_valid lat%0d cyc %0d: got %b want %b", LATS[k], cyc, ov[k], ev);
                end
                if (ev) begin
                    n_cmp++;
                    if (zz[k] !== expq[k][0].z) begin
                        n_fail++;
                        $display("FAIL stream_z lat%0d cyc %0d: got %h want %h", LATS[k], cyc, zz[k], expq[k][0].z);
                    end
                    void'(expq[k].pop_front());
                end
            end
        end
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (expq[k].size() != 0) begin
                n_fail++;
                $display("FAIL stream_drain lat%0d: got %0d outstanding want 0", LATS[k], expq[k].size());
            end
        end
    endtask

    task automatic test_reset_midflight();
        for (int i = 0; i < 16; i++) begin
            logic [31:0] a, b;
            a = rand_float();
            b = rand_float();
            rst = (i == 3);
            if (i < 4 || i == 5) issue(1'b1, a, b, ref_mul(a, b));
            else                 issue(1'b0, a, b, 32'h0);
            tick();
            if (i == 3) begin
                for (int k = 0; k < 3; k++) begin
                    n_cmp++;
                    if (ov[k] !== 1'b0 || zz[k] !== 32'h0) begin
                        n_fail++;
                        $display("FAIL midflight_reset lat%0d: got valid %b z %h want 0 00000000", LATS[k], ov[k], zz[k]);
                    end
                end
            end
            for (int k = 0; k < 3; k++) begin
                logic ev;
                ev = (expq[k].size() > 0) && (expq[k][0].cyc == cyc);
                n_cmp++;
                if (ov[k] !== ev) begin
                    n_fail++;
                    $display("FAIL midflight_valid lat%0d cyc %0d: got %b want %b", LATS[k], cyc, ov[k], ev);
                end
                if (ev) begin
                    n_cmp++;
                    if (zz[k] !== expq[k][0].z) begin
                        n_fail++;
                        $display("FAIL midflight_z lat%0d cyc %0d: got %h want %h", LATS[k], cyc, zz[k], expq[k][0].z);
                    end
                    void'(expq[k].pop_front());
                end
            end
        end
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (expq[k].size() != 0) begin
                n_fail++;
                $display("FAIL midflight_drain lat%0d: got %0d outstanding want 0", LATS[k], expq[k].size());
            end
        end
    endtask

    initial begin
        cyc    = 0;
        n_cmp  = 0;
        n_fail = 0;
        rst    = 1'b1;
        for (int j = 0; j < 4; j++) hist[j] = 32'h0;
        issue(1'b0, 32'h0, 32'h0, 32'h0);

        test_reset();
        test_directed();
        test_stream(1024, 0);
        test_stream(300, 50);
        test_reset_midflight();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
